distribute_chain_source: RTL and testbench



---
 rtl/distribute_chain_source.sv | 135 +++++++++++++
 tb/tb_distribute_chain_source.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/distribute_chain_source.sv
// Injection stage for a one-hot distribute chain: buffers packets in a small FIFO and emits a
// registered data/valid/cmd stream. Define DIST_SRC_DROP_COUNT_EN to add the o_drop_cnt counter.
module distribute_chain_source #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_NODE   = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data_bus,
  input  logic [NUM_NODE-1:0]   i_dest_mask,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data_bus,
  output logic [NUM_NODE-1:0]   o_cmd,
  output logic                  o_en
`ifdef DIST_SRC_DROP_COUNT_EN
  ,
  output logic [7:0]            o_drop_cnt
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [NUM_NODE-1:0]   mask;
  } pkt_t;

  pkt_t                  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_NODE-1:0]   cmd_q, cmd_d;

  logic                  accept_c;
  logic                  wr_c;
  logic                  rd_c;
  logic [NUM_NODE-1:0]   head_cmd_c;
  pkt_t                  head_c;

  assign accept_c = i_valid & ready_q;
  assign wr_c     = accept_c & (|i_dest_mask);
  assign rd_c     = (count_q != '0) & (~valid_q | i_ready);
  assign head_c   = mem_q[rd_ptr_q];

  // Node j is j-th in the chain, so its bit lands at the MSB side of the command.
  always_comb begin
    head_cmd_c = '0;
    for (int j = 0; j < int'(NUM_NODE); j++) begin
      head_cmd_c[NUM_NODE-1-j] = head_c.mask[j];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    data_d   = data_q;
    cmd_d    = cmd_q;
    if (wr_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_c && !rd_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_c && rd_c) begin
      count_d = count_q - CNT_W'(1);
    end
    // Refill the output stage whenever it is empty or being consumed; zeros when nothing is queued.
    if (!valid_q || i_ready) begin
      valid_d = rd_c;
      data_d  = rd_c ? head_c.data : '0;
      cmd_d   = rd_c ? head_cmd_c : '0;
    end
    ready_d = (count_d != CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      data_q   <= '0;
      cmd_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      cmd_q    <= cmd_d;
    end
  end

  // Storage needs no reset: only slots covered by count are ever read.
  always_ff @(posedge clk) begin
    if (wr_c) begin
      mem_q[wr_ptr_q] <= '{data: i_data_bus, mask: i_dest_mask};
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_en       = valid_q;
  assign o_data_bus = data_q;
  assign o_cmd      = cmd_q;

`ifdef DIST_SRC_DROP_COUNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= 8'h00;
    end else if (accept_c && (i_dest_mask == '0) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_distribute_chain_source.sv
// Directed bench for distribute_chain_source: vector table plus backpressure, reset and drop sequences.
module tb_distribute_chain_source;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data_bus;
  logic [7:0]  i_dest_mask;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data_bus;
  logic [7:0]  o_cmd;
  logic        o_en;
`ifdef DIST_SRC_DROP_COUNT_EN
  logic [7:0]  o_drop_cnt;
`endif

  int n_chk;
  int n_fail;

  distribute_chain_source #(.DATA_WIDTH(32), .NUM_NODE(8), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data_bus  (i_data_bus),
    .i_dest_mask (i_dest_mask),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data_bus  (o_data_bus),
    .o_cmd       (o_cmd),
    .o_en        (o_en)
`ifdef DIST_SRC_DROP_COUNT_EN
    ,
    .o_drop_cnt  (o_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [7:0]  m;
    logic        r;
    logic        ev;
    logic [31:0] ed;
    logic [7:0]  ec;
    logic        erdy;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] ed,
                         input logic [7:0] ec, input logic erdy);
    chk({tag, ".o_valid"}, 32'(o_valid), 32'(ev));
    chk({tag, ".o_en"}, 32'(o_en), 32'(ev));
    chk({tag, ".o_data_bus"}, o_data_bus, ed);
    chk({tag, ".o_cmd"}, 32'(o_cmd), 32'(ec));
    chk({tag, ".o_ready"}, 32'(o_ready), 32'(erdy));
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] m, input logic r);
    i_valid     = v;
    i_data_bus  = d;
    i_dest_mask = m;
    i_ready     = r;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    // single packet, back-to-back pair, zero-mask drop
    vecs[0] = '{1'b1, 32'hAAAAAAAA, 8'h01, 1'b1, 1'b0, 32'h0, 8'h00, 1'b1};
    vecs[1] = '{1'b0, 32'h0,        8'h00, 1'b1, 1'b1, 32'hAAAAAAAA, 8'h80, 1'b1};
    vecs[2] = '{1'b0, 32'h0,        8'h00, 1'b1, 1'b0, 32'h0, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 32'h11111111, 8'h80, 1'b1, 1'b0, 32'h0, 8'h00, 1'b1};
    vecs[4] = '{1'b1, 32'h22222222, 8'h03, 1'b1, 1'b1, 32'h11111111, 8'h01, 1'b1};
    vecs[5] = '{1'b0, 32'h0,        8'h00, 1'b1, 1'b1, 32'h22222222, 8'hC0, 1'b1};
    vecs[6] = '{1'b0, 32'h0,        8'h00, 1'b1, 1'b0, 32'h0, 8'h00, 1'b1};
    vecs[7] = '{1'b1, 32'hBBBBBBBB, 8'h00, 1'b1, 1'b0, 32'h0, 8'h00, 1'b1};
    vecs[8] = '{1'b0, 32'h0,        8'h00, 1'b1, 1'b0, 32'h0, 8'h00, 1'b1};
    vecs[9] = '{1'b0, 32'h0,        8'h00, 1'b1, 1'b0, 32'h0, 8'h00, 1'b1};

    rst = 1'b1;
    drive(1'b0, 32'h0, 8'h00, 1'b0);
    #1;
    chk_out("reset", 1'b0, 32'h0, 8'h00, 1'b1);
`ifdef DIST_SRC_DROP_COUNT_EN
    chk("reset.o_drop_cnt", 32'(o_drop_cnt), 32'h0);
`endif
    step();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].m, vecs[i].r);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec, vecs[i].erdy);
    end

    // Backpressure: five accepts fill output stage plus four FIFO slots.
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_ready_before%0d", k), 32'(o_ready), 32'h1);
      drive(1'b1, 32'hB0 + 32'(k), 8'h01 << k, 1'b0);
      step();
      chk($sformatf("bp_ready%0d", k), 32'(o_ready), (k < 4) ? 32'h1 : 32'h0);
      if (k > 0) chk_out($sformatf("bp_hold%0d", k), 1'b1, 32'hB0, 8'h80, (k < 4));
    end
    drive(1'b1, 32'hB5, 8'h20, 1'b0);
    step();
    chk_out("bp_full_hold", 1'b1, 32'hB0, 8'h80, 1'b0);
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    for (int k = 1; k < 5; k++) begin
      step();
      chk_out($sformatf("bp_drain%0d", k), 1'b1, 32'hB0 + 32'(k), 8'h80 >> k, 1'b1);
    end
    step();
    chk_out("bp_drained", 1'b0, 32'h0, 8'h00, 1'b1);

    // Reset while packets are queued and the output is valid.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hC0 + 32'(k), 8'h04, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 8'h00, 1'b0);
    chk("rst_pre.o_valid", 32'(o_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk_out("rst_mid", 1'b0, 32'h0, 8'h00, 1'b1);
    step();
    rst = 1'b0;
    drive(1'b1, 32'hD0, 8'h10, 1'b1);
    step();
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    chk_out("rst_after0", 1'b0, 32'h0, 8'h00, 1'b1);
    step();
    chk_out("rst_after1", 1'b1, 32'hD0, 8'h08, 1'b1);
    step();
    chk_out("rst_after2", 1'b0, 32'h0, 8'h00, 1'b1);

    // Zero-mask packet never reaches the output.
    drive(1'b1, 32'hBBBBBBBB, 8'h00, 1'b1);
    step();
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    chk_out("zero0", 1'b0, 32'h0, 8'h00, 1'b1);
`ifdef DIST_SRC_DROP_COUNT_EN
    chk("drop_cnt_one", 32'(o_drop_cnt), 32'h1);
`endif
    step();
    chk_out("zero1", 1'b0, 32'h0, 8'h00, 1'b1);
`ifdef DIST_SRC_DROP_COUNT_EN
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 32'hBBBBBBBB, 8'h00, 1'b1);
      step();
    end
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    chk("drop_cnt_sat", 32'(o_drop_cnt), 32'hFF);
    chk("drop_sat.o_valid", 32'(o_valid), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
